// File: rtl/ysyx_22050368_mdu.sv
// ysyx_22050368_mdu: iterative RV M-extension multiply/divide unit with valid/ready handshake
// Radix-2 shift-add multiply and restoring divide on absolute values, sign fixed up in a final cycle.
module ysyx_22050368_mdu #(
  parameter int XLEN     = 64,
  parameter bit WORD_OPS = 1,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       in_op_i,
  input  logic             in_word_i,
  input  logic [XLEN-1:0]  in_rs1_i,
  input  logic [XLEN-1:0]  in_rs2_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  out_data_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             busy_o
);
  localparam int CW = $clog2(XLEN) + 1;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
  state_e state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              word_q, word_d, negq_q, negq_d, negr_q, negr_d;
  logic [TAG_W-1:0]  tag_q, tag_d, otag_q, otag_d;
  logic [CW-1:0]     cnt_q, cnt_d, last;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, rem_q, rem_d, data_q, data_d;
  logic [2*XLEN-1:0] mc_q, mc_d, acc_q, acc_d, p;
  logic              wd, is_div, s1, s2, n1, n2, div0, ovf, fast, brw;
  logic [XLEN-1:0]   x1, x2, abs1, abs2, fres, fdata, diff, q, r, m, raw, res;
  logic [XLEN:0]     t;
  function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction
  assign wd     = WORD_OPS && XLEN == 64 && in_word_i;
  assign is_div = in_op_i[2];
  assign s1     = is_div ? ~in_op_i[0] : in_op_i[1] ^ in_op_i[0];
  assign s2     = is_div ? ~in_op_i[0] : in_op_i[1:0] == 2'b01;
  assign x1     = wd ? (s1 ? sx(in_rs1_i[31:0]) : XLEN'(in_rs1_i[31:0])) : in_rs1_i;
  assign x2     = wd ? (s2 ? sx(in_rs2_i[31:0]) : XLEN'(in_rs2_i[31:0])) : in_rs2_i;
  assign n1     = s1 & x1[XLEN-1];
  assign n2     = s2 & x2[XLEN-1];
  assign abs1   = n1 ? -x1 : x1;
  assign abs2   = n2 ? -x2 : x2;
  // Divide fast paths: x/0 and most-negative/-1 resolve without iterating
  assign div0   = x2 == '0;
  assign ovf    = ~in_op_i[0] & x2 == '1 & (wd ? x1[31:0] == 32'h8000_0000 : x1 == {1'b1, {(XLEN-1){1'b0}}});
  assign fast   = is_div & (div0 | ovf);
  assign fres   = div0 ? (in_op_i[1] ? x1 : '1) : (in_op_i[1] ? '0 : x1);
  assign fdata  = wd ? sx(fres[31:0]) : fres;
  // Restoring divide step: partial remainder lives in rem_q, dividend/quotient shifts through a_q
  assign t      = {rem_q, a_q[XLEN-1]};
  assign brw    = t < {1'b0, b_q};
  assign diff   = t[XLEN-1:0] - b_q;
  assign last   = word_q ? CW'(31) : CW'(XLEN-1);
  assign p      = negq_q ? -acc_q : acc_q;
  assign q      = negq_q ? -a_q : a_q;
  assign r      = negr_q ? -rem_q : rem_q;
  assign m      = op_q[1:0] == 2'b00 ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  assign raw    = op_q[2] ? (op_q[1] ? r : q) : m;
  assign res    = word_q ? sx(raw[31:0]) : raw;
  assign in_ready_o  = state_q == IDLE;
  assign busy_o      = state_q != IDLE;
  assign out_valid_o = state_q == DONE;
  assign out_data_o  = data_q;
  assign out_tag_o   = otag_q;
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    word_d  = word_q;
    tag_d   = tag_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    mc_d    = mc_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    data_d  = data_q;
    otag_d  = otag_q;
    if (flush_i) state_d = IDLE;
    else
      unique case (state_q)
        IDLE: if (in_valid_i) begin
          op_d    = in_op_i;
          word_d  = wd;
          tag_d   = in_tag_i;
          negq_d  = n1 ^ n2;
          negr_d  = n1;
          cnt_d   = '0;
          a_d     = is_div ? (wd ? abs1 << (XLEN-32) : abs1) : abs2;
          b_d     = abs2;
          mc_d    = {{XLEN{1'b0}}, abs1};
          acc_d   = '0;
          rem_d   = '0;
          state_d = fast ? DONE : CALC;
          data_d  = fast ? fdata : data_q;
          otag_d  = fast ? in_tag_i : otag_q;
        end
        CALC: begin
          a_d     = op_q[2] ? {a_q[XLEN-2:0], ~brw} : a_q >> 1;
          rem_d   = op_q[2] ? (brw ? t[XLEN-1:0] : diff) : rem_q;
          acc_d   = (~op_q[2] & a_q[0]) ? acc_q + mc_q : acc_q;
          mc_d    = mc_q << 1;
          cnt_d   = cnt_q + CW'(1);
          state_d = cnt_q == last ? FIX : CALC;
        end
        FIX: begin
          data_d  = res;
          otag_d  = tag_q;
          state_d = DONE;
        end
        default: state_d = out_ready_i ? IDLE : DONE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      word_q  <= 1'b0;
      tag_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mc_q    <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      otag_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      word_q  <= word_d;
      tag_q   <= tag_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mc_q    <= mc_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      otag_q  <= otag_d;
    end
endmodule

// File: doc/ysyx_22050368_mdu.md
Name: ysyx_22050368_mdu

Overview:
Iterative multiply/divide unit implementing the RV M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, plus RV64 W-variants). It sits beside the single-cycle ALU/BJP execute path. The execute stage dispatches M-ops here through a valid/ready handshake and receives the writeback data, tagged with the destination register, when the operation completes. It is the multi-cycle, width-parametrised successor to the combinational execute datapath.

Parameters:
XLEN, 64, datapath width in bits (32 or 64).
WORD_OPS, 1, when 1 and XLEN==64, in_word selects 32-bit W-variant ops; when 0, in_word is ignored.
TAG_W, 5, width of the passthrough destination tag.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  abort the in-flight op; drop any pending result
in_valid  input  1  request valid
in_ready  output  1  unit can accept; high only in IDLE
in_op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
in_word  input  1  W-variant (MULW/DIVW/DIVUW/REMW/REMUW)
in_rs1  input  XLEN  operand 1 (multiplicand / dividend)
in_rs2  input  XLEN  operand 2 (multiplier / divisor)
in_tag  input  TAG_W  destination tag, returned unchanged
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  XLEN  result
out_tag  output  TAG_W  tag of the op that produced out_data
busy  output  1  high in every state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, out_data=0, out_tag=0, busy=0, counter=0, so in_ready=1. Reset mid-operation discards the op and emits no result.
- Accept: in_valid & in_ready & ~flush at a rising edge latches op, word, tag and operands.
- Word ops: operands are taken from bits [31:0], sign-extended for signed ops and zero-extended for unsigned ops. Iteration count N=32. The result is bits [31:0] sign-extended to XLEN. Otherwise N=XLEN.
- Signed handling: latch absolute values and a result-sign flag. The core computes unsigned values, and FIX negates as required.
  - MULH: both operands signed. MULHSU: rs1 signed, rs2 unsigned. MULHU: both unsigned.
  - Remainder takes the dividend's sign.
- States:
  - IDLE -> CALC on accept (normal case).
  - IDLE -> DONE on accept for the divide fast paths:
    - divisor==0: quotient = all-ones (DIV and DIVU); remainder = dividend.
    - signed overflow (most-negative / -1, at the op's width): quotient = dividend; remainder = 0.
  - CALC: radix-2, one bit per cycle for N cycles. Multiply uses a shift-add 2N-bit product register. Divide uses restoring shift-subtract.
  - CALC -> FIX when the counter reaches N-1.
  - FIX (1 cycle): sign fixup; select the low product (MUL), high product (MULH*), quotient or remainder; apply word sign-extension. FIX -> DONE.
  - DONE: out_valid=1 and out_data/out_tag are stable. DONE -> IDLE on out_ready.
- Latency: accept at edge T gives out_valid after edge T+N+2 (66 cycles for 64-bit ops, 34 for W-ops). Fast paths give out_valid after edge T+1.
- Backpressure: out_valid, out_data and out_tag are held indefinitely while out_ready=0. There is no new accept until the result drains.
- Throughput: in_ready is combinational (state==IDLE). A new op is accepted only from IDLE, so the earliest next accept is the cycle after the out_ready handshake.
- Flush: synchronous, highest priority over every other input. From any state, the next state is IDLE with out_valid=0; it takes effect at the same edge. An in_valid coinciding with flush is not accepted. A flush in DONE that coincides with out_ready counts as a flush (result dropped).
- out_data and out_tag keep their last values when out_valid=0; consumers qualify them with out_valid.
- No X propagation: unused product/remainder bits are driven deterministically.

Test Plan:
- MUL rs1=3, rs2=0xFFFF_FFFF_FFFF_FFFB (-5), tag=7 -> after 66 cycles out_valid, out_data=0xFFFF_FFFF_FFFF_FFF1, out_tag=7. MULHU all-ones × all-ones -> 0xFFFF_FFFF_FFFF_FFFE. MULH same operands -> 0.
- DIV -7/2 -> 0xFFFF_FFFF_FFFF_FFFD (-3). REM -7/2 -> 0xFFFF_FFFF_FFFF_FFFF (-1). DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Fast paths:
  - DIV 5/0 -> all-ones and REM 5/0 -> 5, each with out_valid one edge after accept.
  - DIV 0x8000_0000_0000_0000/-1 -> 0x8000_0000_0000_0000, with REM -> 0.
- W-ops: DIVW rs1=0x0000_0001_8000_0000, rs2=-1 -> 0xFFFF_FFFF_8000_0000 (overflow path). MULW 0x7FFF_FFFF×2 -> 0xFFFF_FFFF_FFFF_FFFE after 34 cycles.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> data and tag stable, in_ready=0 throughout. A single out_ready pulse -> in_ready=1 the next cycle.
- Abort: flush at CALC cycle 10 -> IDLE next edge, no out_valid. Flush together with in_valid -> no accept. rst_n low mid-CALC -> all outputs at reset values immediately. A subsequent op completes correctly.
